// File: rtl/avalon_arb_2m1s.sv
// rtl/avalon_arb_2m1s.sv - round-robin two-master, one-slave Avalon-MM arbiter
module avalon_arb_2m1s #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant,
  output logic [31:0]         done0,
  output logic [31:0]         done1
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   last_q;
  logic   req0, req1;
  logic   cmpl0, cmpl1;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign cmpl0 = (state_q == GNT0) & req0 & ~s_waitrequest;
  assign cmpl1 = (state_q == GNT1) & req1 & ~s_waitrequest;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      done0   <= '0;
      done1   <= '0;
    end else begin
      state_q <= state_d;
      if (cmpl0) begin
        last_q <= 1'b0;
        done0  <= done0 + 32'd1;
      end
      if (cmpl1) begin
        last_q <= 1'b1;
        done1  <= done1 + 32'd1;
      end
    end
  end

  // Every transaction returns to IDLE, so contention always alternates via last_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0:    if (!req0 || !s_waitrequest) state_d = IDLE;
      GNT1:    if (!req1 || !s_waitrequest) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address      = m0_address;
    s_writedata    = m0_writedata;
    s_byteenable   = m0_byteenable;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    case (state_q)
      GNT0: begin
        s_read         = m0_read;
        s_write        = m0_write;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      GNT1: begin
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_read         = m1_read;
        s_write        = m1_write;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_avalon_arb_2m1s.sv
// tb/tb_avalon_arb_2m1s.sv - directed vector bench for avalon_arb_2m1s
module tb_avalon_arb_2m1s;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write, s_waitrequest;
  logic [1:0]  grant;
  logic [31:0] done0, done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_arb_2m1s dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest), .grant(grant), .done0(done0), .done1(done1)
  );

  typedef struct {
    logic        rst, r0, w0, r1, w1, sw;
    logic [1:0]  e_gnt;
    logic        e_sr, e_sw, e_q0, e_q1;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, r0, w0, r1, w1, sw, logic [1:0] g,
                              logic sr, swr, q0, q1, logic [31:0] d0, d1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.sw = sw;
    v.e_gnt = g; v.e_sr = sr; v.e_sw = swr; v.e_q0 = q0; v.e_q1 = q1;
    v.e_d0 = d0; v.e_d1 = d1;
    return v;
  endfunction

  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, r0, w0, r1, w1, sw);
    reset = rst; m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1;
    s_waitrequest = sw;
  endtask

  initial begin
    m0_address = A0; m1_address = A1;
    m0_writedata = 32'h1111_0000; m1_writedata = 32'h2222_0000;
    m0_byteenable = 4'h3; m1_byteenable = 4'hC;
    s_readdata = RD;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    //            rst r0 w0 r1 w1 sw  gnt    sr sw q0 q1 d0 d1
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 2'b10, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 2'b10, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 1, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2'b01, 1, 0, 1, 1, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 2'b01, 0, 1, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 1, 1, 2, 2));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 2'b10, 1, 0, 1, 0, 2, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2, 3));

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1, vecs[i].sw);
      #1;
      chk($sformatf("vec%0d", i),
          {grant, s_read, s_write, m0_waitrequest, m1_waitrequest, s_address,
           m0_readdata, m1_readdata, done0, done1},
          {vecs[i].e_gnt, vecs[i].e_sr, vecs[i].e_sw, vecs[i].e_q0, vecs[i].e_q1,
           (vecs[i].e_gnt == 2'b10) ? A1 : A0, RD, RD, vecs[i].e_d0, vecs[i].e_d1});
    end

    // reset while a GNT0 read is stalled
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("stall_gnt0", {grant, s_read, m0_waitrequest}, {2'b01, 1'b1, 1'b1});
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); #1;
    chk("reset_mid", {grant, s_read, s_write, m0_waitrequest, m1_waitrequest, done0, done1},
        {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0});
    @(negedge clk); #1;
    chk("first_tie_m0", grant, 2'b01);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // done1 wrap
    @(negedge clk);
    force dut.done1 = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.done1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("wrap_gnt1", {grant, m1_waitrequest, done1}, {2'b10, 1'b0, 32'hFFFF_FFFF});
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("wrap_done", {done0, done1}, {32'd0, 32'd0});

    // contention: four writes each, zero-wait slave
    @(negedge clk); reset = 1'b0;
    begin
      int i0 = 0, i1 = 0;
      logic exp_m1 = 1'b0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        reset = 1'b1; s_waitrequest = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
        m0_write = (i0 < 4); m0_writedata = 32'hA000_0000 + i0;
        m0_byteenable = 4'(4'b0001 << i0);
        m1_write = (i1 < 4); m1_writedata = 32'hB000_0000 + i1;
        m1_byteenable = 4'(4'b1000 >> i1);
        #1;
        if (m0_write && !m0_waitrequest) begin
          chk($sformatf("cont_m0_%0d", i0), {exp_m1, grant, s_write, s_writedata, s_byteenable},
              {1'b0, 2'b01, 1'b1, 32'hA000_0000 + i0, 4'(4'b0001 << i0)});
          i0++; exp_m1 = ~exp_m1;
        end
        if (m1_write && !m1_waitrequest) begin
          chk($sformatf("cont_m1_%0d", i1), {exp_m1, grant, s_write, s_writedata, s_byteenable},
              {1'b1, 2'b10, 1'b1, 32'hB000_0000 + i1, 4'(4'b1000 >> i1)});
          i1++; exp_m1 = ~exp_m1;
        end
      end
      @(negedge clk); m0_write = 1'b0; m1_write = 1'b0; #1;
      chk("cont_done", {done0, done1, 32'(i0), 32'(i1)}, {32'd4, 32'd4, 32'd4, 32'd4});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
